display_hex_scan: RTL and testbench
===================================

DISPLAY_HEX_SCAN -- requirements
Module: display_hex_scan

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 3, number of multiplexed 7-segment digits (legal range 1..8).
REQ-002 SHALL have parameter REFRESH_RATE, default 1000, full-frame refresh rate in Hz.
REQ-003 SHALL have parameter SYS_CLK_FREQ, default 100000000, clk frequency in Hz.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port value, input, 4*NUM_DIGITS, the hex value; nibble i drives digit i, and digit NUM_DIGITS-1 is the leftmost.
REQ-007 SHALL have port dp, input, NUM_DIGITS, decimal-point request per digit.
REQ-008 SHALL have port brightness, input, 3, duty level 0..7.
REQ-009 SHALL have port segments, output, 8, active-low; bit7..bit1 = a..g and bit0 = dp.
REQ-010 SHALL have port segments_enable, output, NUM_DIGITS, active-low digit select; bit i selects digit i.
REQ-011 SHALL have port frame_done, output, 1, a one-cycle pulse per completed frame.

Function
REQ-012 SHALL derive SLOT_CYCLES = SYS_CLK_FREQ/(REFRESH_RATE*NUM_DIGITS) at elaboration and fail elaboration if SLOT_CYCLES < 8 or NUM_DIGITS is outside 1..8.
REQ-013 SHALL count divider 0..SLOT_CYCLES-1, then wrap to 0 and advance the digit index.
REQ-014 SHALL scan digits left to right: index NUM_DIGITS-1 down to 0, then wrap to NUM_DIGITS-1.
REQ-015 SHALL define the frame-end cycle as divider==SLOT_CYCLES-1 with index==0.
REQ-016 SHALL capture value and dp into shadow registers at every frame-end edge; changes mid-frame have no effect until the next frame.
REQ-017 SHALL assert frame_done for exactly the one cycle following each frame-end edge.
REQ-018 SHALL compute on_cycles = ((brightness+1)*SLOT_CYCLES)/8 and light the current digit only while divider < on_cycles; otherwise all enables and segments are off.
REQ-019 SHALL sample brightness continuously; a change takes effect from the next cycle.
REQ-020 SHALL drive exactly one enable bit active while lit, and none while dark.
REQ-021 SHALL register outputs; segments and segments_enable lag the internal divider/index by exactly one clock.
REQ-022 SHALL decode nibbles using the standard hex glyphs: 0=FC 1=60 2=DA 3=F2 4=66 5=B6 6=BE 7=E0 8=FE 9=F6 A=EE b=3E C=9C d=7A E=9E F=8E (internal active-high), with the dp bit ORed into bit0 and the whole byte inverted at the port.

Reset
REQ-023 SHALL, with rst high, set next-edge outputs to segments=all 1, segments_enable=all 1, frame_done=0, divider=0, index=NUM_DIGITS-1, and shadow registers=0.
REQ-024 SHALL, on rst asserted mid-slot or mid-frame, abandon the frame without a frame_done pulse.
REQ-025 SHALL show the shadow contents (zeros) in the first frame after reset; value captured at the first frame end appears in the second frame.

Configuration
REQ-026 SHALL, with DISPLAY_HEX_SCAN_BLANK_EN defined, blank leading-zero digits: a-g off for every zero nibble above the most significant non-zero nibble. Digit 0 is never blanked. The dp of a blanked digit still displays.
REQ-027 SHALL, without DISPLAY_HEX_SCAN_BLANK_EN, display every digit, including leading zeros.

Structure
REQ-028 SHALL place the glyph table function, the SEG_OFF constant and the segment bit-position constants in package display_hex_pkg.
REQ-029 SHALL use one combinational sub-module, hex_seg_decode (nibble, dp -> 8-bit active-high segments), instantiated once on the muxed shadow nibble.

Verification (NUM_DIGITS=4, SYS_CLK_FREQ=3200, REFRESH_RATE=100 -> SLOT_CYCLES=8)
REQ-030 SHALL cover reset: rst high 3 cycles -> segments=FF, segments_enable=F, frame_done=0 throughout.
REQ-031 SHALL cover scan: value=1A3F, dp=0, brightness=7, second frame -> enable sequence 7,B,D,E for 8 cycles each, segments 9F,11,0D,71, and one frame_done every 32 cycles.
REQ-032 SHALL cover dimming: brightness=3 -> each slot has its enable active for 4 cycles, then enable=F and segments=FF for 4 cycles.
REQ-033 SHALL cover tearing: value changes 1234->5678 during slot 2 of frame N -> frame N shows 1,2,3,4 and frame N+1 shows 5,6,7,8.
REQ-034 SHALL cover blanking (macro on): value=000F -> segments FF,FF,FF,71; value=0000 -> FF,FF,FF,03; dp=1000 with value=000F -> leftmost digit FE.
REQ-035 SHALL cover mid-slot reset: rst pulsed at divider=4 of slot 2 -> outputs off the next cycle, no frame_done, and the scan restarts at the leftmost digit.

Source files
------------

// File: rtl/display_hex_pkg.sv
// Shared constants and the hex glyph table for the multiplexed 7-segment scanner.
// Segment bytes are active-high here: bit7..bit1 = a..g, bit0 = decimal point.
package display_hex_pkg;

    localparam int SEG_A_BIT  = 7;
    localparam int SEG_G_BIT  = 1;
    localparam int SEG_DP_BIT = 0;

    // Port-level (active-low) byte with every segment dark.
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Bits a..g only, used to strip glyphs while keeping the decimal point.
    localparam logic [7:0] SEG_AG_MASK = 8'((1 << (SEG_A_BIT + 1)) - (1 << SEG_G_BIT));

    function automatic logic [7:0] hex_glyph(input logic [3:0] nibble);
        logic [7:0] glyph;
        case (nibble)
            4'h0: glyph = 8'hFC;
            4'h1: glyph = 8'h60;
            4'h2: glyph = 8'hDA;
            4'h3: glyph = 8'hF2;
            4'h4: glyph = 8'h66;
            4'h5: glyph = 8'hB6;
            4'h6: glyph = 8'hBE;
            4'h7: glyph = 8'hE0;
            4'h8: glyph = 8'hFE;
            4'h9: glyph = 8'hF6;
            4'hA: glyph = 8'hEE;
            4'hB: glyph = 8'h3E;
            4'hC: glyph = 8'h9C;
            4'hD: glyph = 8'h7A;
            4'hE: glyph = 8'h9E;
            default: glyph = 8'h8E;
        endcase
        return glyph & SEG_AG_MASK;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational nibble-to-glyph decoder with decimal point, active-high output.
module hex_seg_decode
    import display_hex_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] segments
);

    // Look up the glyph and drop the decimal-point request into its bit.
    always_comb begin
        segments             = hex_glyph(nibble);
        segments[SEG_DP_BIT] = dp;
    end

endmodule

// File: rtl/display_hex_scan.sv
// Time-multiplexed hex display driver: scans NUM_DIGITS digits left to right,
// dims each slot by brightness, and latches value/dp once per frame so a frame
// never shows a mix of old and new data.
// Optional leading-zero blanking is enabled by defining DISPLAY_HEX_SCAN_BLANK_EN.
module display_hex_scan
    import display_hex_pkg::*;
#(
    parameter int NUM_DIGITS   = 3,
    parameter int REFRESH_RATE = 1000,
    parameter int SYS_CLK_FREQ = 100000000
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [2:0]              brightness,
    output logic [7:0]              segments,
    output logic [NUM_DIGITS-1:0]   segments_enable,
    output logic                    frame_done
);

    localparam int SLOT_CYCLES = SYS_CLK_FREQ / (REFRESH_RATE * NUM_DIGITS);
    localparam int DIV_W       = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int ON_W        = DIV_W + 4;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SLOT_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
        $error("display_hex_scan: NUM_DIGITS must be within 1..8");
    end
    if (SLOT_CYCLES < 8) begin : g_bad_slot
        $error("display_hex_scan: SLOT_CYCLES must be at least 8");
    end

    logic [DIV_W-1:0]        divider;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] shadow_value;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic                    frame_end;
    logic [ON_W-1:0]         on_product;
    logic [ON_W-1:0]         on_cycles;
    logic                    lit;
    logic [3:0]              cur_nibble;
    logic                    cur_dp;
    logic [NUM_DIGITS-1:0]   digit_select;
    logic                    blank_digit;
    logic [7:0]              decoded;
    logic [7:0]              shown;

    assign frame_end  = (divider == DIV_LAST) && (idx == '0);
    assign on_product = (ON_W'(brightness) + ON_W'(1)) * ON_W'(SLOT_CYCLES);
    assign on_cycles  = on_product >> 3;
    assign lit        = ON_W'(divider) < on_cycles;

    // Pick the shadow nibble, dp bit and one-hot select for the digit being scanned.
    always_comb begin
        cur_nibble   = '0;
        cur_dp       = 1'b0;
        digit_select = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_nibble      = shadow_value[4*i +: 4];
                cur_dp          = shadow_dp[i];
                digit_select[i] = 1'b1;
            end
        end
    end

`ifdef DISPLAY_HEX_SCAN_BLANK_EN
    logic [NUM_DIGITS-1:0] leading_zero;

    // Mark every zero nibble above the most significant non-zero one; digit 0 always shows.
    always_comb begin
        logic seen_nonzero;
        seen_nonzero = 1'b0;
        leading_zero = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            seen_nonzero    = seen_nonzero | (shadow_value[4*i +: 4] != 4'h0);
            leading_zero[i] = ~seen_nonzero;
        end
    end

    assign blank_digit = |(leading_zero & digit_select);
`else
    assign blank_digit = 1'b0;
`endif

    hex_seg_decode u_decode (
        .nibble   (cur_nibble),
        .dp       (cur_dp),
        .segments (decoded)
    );

    assign shown = blank_digit ? (decoded & ~SEG_AG_MASK) : decoded;

    // Slot divider and digit index, stepping leftmost to rightmost and wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            divider <= '0;
            idx     <= IDX_FIRST;
        end else if (divider == DIV_LAST) begin
            divider <= '0;
            idx     <= (idx == '0) ? IDX_FIRST : idx - IDX_W'(1);
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

    // Latch the displayed data only at frame end so a frame is never torn.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
        end else if (frame_end) begin
            shadow_value <= value;
            shadow_dp    <= dp;
        end
    end

    // Registered active-low outputs, one clock behind the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            segments        <= SEG_OFF;
            segments_enable <= '1;
            frame_done      <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (lit) begin
                segments        <= ~shown;
                segments_enable <= ~digit_select;
            end else begin
                segments        <= SEG_OFF;
                segments_enable <= '1;
            end
        end
    end

endmodule

// File: tb/tb_display_hex_scan.sv
// Self-checking bench for display_hex_scan with 4 digits and 8-cycle slots.
// A frame-position model checks outputs every cycle; directed frames pin literals.
module tb_display_hex_scan;

    localparam int NUM_DIGITS = 4;
    localparam int SLOT       = 8;
    localparam int FRAME      = NUM_DIGITS * SLOT;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [2:0]  brightness;
    logic [7:0]  segments;
    logic [3:0]  segments_enable;
    logic        frame_done;

    int compared   = 0;
    int mismatched = 0;

    logic [7:0] GLYPH [16] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
                               8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

    display_hex_scan #(
        .NUM_DIGITS   (NUM_DIGITS),
        .REFRESH_RATE (100),
        .SYS_CLK_FREQ (3200)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .value           (value),
        .dp              (dp),
        .brightness      (brightness),
        .segments        (segments),
        .segments_enable (segments_enable),
        .frame_done      (frame_done)
    );

    always #5 clk = ~clk;

    // Active-high byte a digit should show given the latched frame data.
    function automatic logic [7:0] digit_byte(input logic [15:0] v, input logic [3:0] d, input int digit);
        logic [3:0] nib;
        logic       blank;
        nib   = v[4*digit +: 4];
        blank = 1'b0;
`ifdef DISPLAY_HEX_SCAN_BLANK_EN
        begin
            int msd;
            msd = 0;
            for (int j = 0; j < NUM_DIGITS; j++)
                if (v[4*j +: 4] != 4'h0) msd = j;
            blank = digit > msd;
        end
`endif
        return (blank ? 8'h00 : GLYPH[nib]) | {7'b0, d[digit]};
    endfunction

    // Behavioural model: position in frame = cycles since reset mod FRAME.
    logic [7:0]  exp_seg;
    logic [3:0]  exp_en;
    logic        exp_fd;
    logic        model_valid = 1'b0;
    logic [15:0] sh_val;
    logic [3:0]  sh_dp;
    int          t_since_rst;

    always @(posedge clk) begin
        if (rst) begin
            exp_seg     = 8'hFF;
            exp_en      = 4'hF;
            exp_fd      = 1'b0;
            sh_val      = 16'h0;
            sh_dp       = 4'h0;
            t_since_rst = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            int pos, digit, phase, on;
            pos   = t_since_rst % FRAME;
            digit = NUM_DIGITS - 1 - pos / SLOT;
            phase = pos % SLOT;
            on    = ((int'(brightness) + 1) * SLOT) / 8;
            if (phase < on) begin
                exp_en  = ~(4'b1 << digit);
                exp_seg = ~digit_byte(sh_val, sh_dp, digit);
            end else begin
                exp_en  = 4'hF;
                exp_seg = 8'hFF;
            end
            exp_fd = (pos == FRAME - 1);
            if (pos == FRAME - 1) begin
                sh_val = value;
                sh_dp  = dp;
            end
            t_since_rst++;
        end
    end

    // Compare DUT against the model on every falling edge.
    always @(negedge clk) begin
        if (model_valid) begin
            compared++;
            if (segments !== exp_seg || segments_enable !== exp_en || frame_done !== exp_fd) begin
                mismatched++;
                $display("[TB] FAIL model_cmp @%0t: got seg=%h en=%h fd=%b, expected seg=%h en=%h fd=%b",
                         $time, segments, segments_enable, frame_done, exp_seg, exp_en, exp_fd);
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [2:0] b);
        value      = v;
        dp         = d;
        brightness = b;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] seg, input logic [3:0] en, input logic fd);
        compared++;
        if (segments !== seg || segments_enable !== en || frame_done !== fd) begin
            mismatched++;
            $display("[TB] FAIL %s @%0t: got seg=%h en=%h fd=%b, expected seg=%h en=%h fd=%b",
                     name, $time, segments, segments_enable, frame_done, seg, en, fd);
        end
    endtask

    // Check one full-brightness frame; called on the falling edge just before it starts.
    task automatic check_frame(input string name, input logic [31:0] segs,
                               input logic [15:0] nxt_val, input logic [3:0] nxt_dp,
                               input int tear_at, input logic [15:0] tear_val);
        for (int i = 0; i < FRAME; i++) begin
            int d;
            @(negedge clk);
            d = NUM_DIGITS - 1 - i / SLOT;
            checkOutput(name, segs[8*d +: 8], ~(4'b1 << d), i == FRAME - 1);
            if (i == 0) begin
                value = nxt_val;
                dp    = nxt_dp;
            end
            if (i == tear_at) value = tear_val;
        end
    endtask

    initial begin
        int rst_left;
        logic [31:0] scan_segs;
        rst = 1'b1;
        applyStimulus(16'h1A3F, 4'h0, 3'd7);

        repeat (3) begin
            @(negedge clk);
            checkOutput("reset", 8'hFF, 4'hF, 1'b0);
        end
        rst = 1'b0;

        check_frame("zero_frame", 32'h03030303, 16'h1A3F, 4'h0, -1, 16'h0);
        check_frame("scan",       32'h9F110D71, 16'h1A3F, 4'h0, -1, 16'h0);

        brightness = 3'd3;
        scan_segs  = 32'h9F110D71;
        for (int i = 0; i < FRAME; i++) begin
            int d;
            logic on;
            @(negedge clk);
            d  = NUM_DIGITS - 1 - i / SLOT;
            on = (i % SLOT) < 4;
            checkOutput("dim", on ? scan_segs[8*d +: 8] : 8'hFF, on ? ~(4'b1 << d) : 4'hF, i == FRAME - 1);
            if (i == 0) value = 16'h1234;
        end
        brightness = 3'd7;

        check_frame("tear_n",  32'h9F250D99, 16'h1234, 4'h0, 12, 16'h5678);
        check_frame("tear_n1", 32'h49411F01, 16'h000F, 4'h0, -1, 16'h0);
`ifdef DISPLAY_HEX_SCAN_BLANK_EN
        check_frame("blank_f",    32'hFFFFFF71, 16'h0000, 4'h0, -1, 16'h0);
        check_frame("blank_zero", 32'hFFFFFF03, 16'h000F, 4'h8, -1, 16'h0);
        check_frame("blank_dp",   32'hFEFFFF71, 16'h1A3F, 4'h0, -1, 16'h0);
`else
        check_frame("noblank_f",    32'h03030371, 16'h0000, 4'h0, -1, 16'h0);
        check_frame("noblank_zero", 32'h03030303, 16'h000F, 4'h8, -1, 16'h0);
        check_frame("noblank_dp",   32'h02030371, 16'h1A3F, 4'h0, -1, 16'h0);
`endif

        for (int i = 0; i < 12; i++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_off", 8'hFF, 4'hF, 1'b0);
        rst = 1'b0;
        check_frame("midrst_restart", 32'h03030303, 16'h1A3F, 4'h0, -1, 16'h0);

        rst_left = 0;
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst      = 1'b1;
                rst_left = $urandom_range(1, 3);
            end
            if ($urandom_range(0, 15) == 0) value = 16'($urandom);
            if ($urandom_range(0, 15) == 0) value = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 15) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 7) == 0)  brightness = 3'($urandom);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
